// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory with a
// valid/ready request channel and read data returned one cycle after the handshake.
module mem_arbiter #(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_0,
    input  logic                  req_wr_rd_0,
    input  logic [ADDR_WIDTH-1:0] req_addr_0,
    input  logic [WIDTH-1:0]      req_wdata_0,
    input  logic                  req_valid_1,
    input  logic                  req_wr_rd_1,
    input  logic [ADDR_WIDTH-1:0] req_addr_1,
    input  logic [WIDTH-1:0]      req_wdata_1,
    output logic                  req_ready_0,
    output logic                  req_ready_1,
    output logic                  rsp_valid_0,
    output logic                  rsp_valid_1,
    output logic [WIDTH-1:0]      rsp_rdata_0,
    output logic [WIDTH-1:0]      rsp_rdata_1,
    output logic                  mem_valid,
    output logic                  mem_wr_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_ready
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] RDWAIT = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]            state_reg, state_next;
    logic                  ptr_reg;
    logic                  owner_reg;
    logic                  wr_rd_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [WIDTH-1:0]      wdata_reg;
    logic                  any_req;
    logic                  grant_sel;
    logic                  grant_cycle;

    // The pointer only breaks ties; a lone requester always wins.
    assign any_req     = req_valid_0 | req_valid_1;
    assign grant_sel   = (req_valid_0 && req_valid_1) ? ptr_reg : req_valid_1;
    assign grant_cycle = (state_reg == IDLE) && any_req && !rst;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   if (mem_ready) state_next = wr_rd_reg ? RESP : RDWAIT;
            RDWAIT:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b0;
            owner_reg <= 1'b0;
            wr_rd_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (grant_cycle) begin
                owner_reg <= grant_sel;
                ptr_reg   <= ~grant_sel;
                wr_rd_reg <= grant_sel ? req_wr_rd_1 : req_wr_rd_0;
                addr_reg  <= grant_sel ? req_addr_1  : req_addr_0;
                wdata_reg <= grant_sel ? req_wdata_1 : req_wdata_0;
            end
        end
    end

    // Each requester keeps its own read-data register so a read for one
    // never disturbs the value last returned to the other.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_rsp
            localparam logic SEL = 1'(gi);
            logic [WIDTH-1:0] rdata_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_reg <= '0;
                end else if (state_reg == RDWAIT && owner_reg == SEL) begin
                    rdata_reg <= mem_rdata;
                end
            end
        end
    endgenerate

    assign req_ready_0 = grant_cycle && !grant_sel;
    assign req_ready_1 = grant_cycle && grant_sel;
    assign rsp_valid_0 = (state_reg == RESP) && !owner_reg;
    assign rsp_valid_1 = (state_reg == RESP) && owner_reg;
    assign rsp_rdata_0 = gen_rsp[0].rdata_reg;
    assign rsp_rdata_1 = gen_rsp[1].rdata_reg;
    assign mem_valid   = (state_reg == ISSUE);
    assign mem_wr_rd   = wr_rd_reg;
    assign mem_addr    = addr_reg;
    assign mem_wdata   = wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: timeline-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;

    localparam int DEPTH = 16;
    localparam int WIDTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid_0 = 1'b0, req_wr_rd_0 = 1'b0;
    logic [AW-1:0]    req_addr_0 = '0;
    logic [WIDTH-1:0] req_wdata_0 = '0;
    logic             req_valid_1 = 1'b0, req_wr_rd_1 = 1'b0;
    logic [AW-1:0]    req_addr_1 = '0;
    logic [WIDTH-1:0] req_wdata_1 = '0;
    logic             req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
    logic [WIDTH-1:0] rsp_rdata_0, rsp_rdata_1;
    logic             mem_valid, mem_wr_rd;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata = '0;
    logic             mem_ready = 1'b1;

    always #5 clk = ~clk;

    mem_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_wr_rd_0(req_wr_rd_0),
        .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
        .req_valid_1(req_valid_1), .req_wr_rd_1(req_wr_rd_1),
        .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_rdata_0(rsp_rdata_0), .rsp_rdata_1(rsp_rdata_1),
        .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // Memory device: read data appears the cycle after the handshake, noise otherwise.
    logic [WIDTH-1:0] dev_mem [DEPTH];
    always @(posedge clk) begin
        if (mem_valid && mem_ready && mem_wr_rd) dev_mem[mem_addr] <= mem_wdata;
        if (mem_valid && mem_ready && !mem_wr_rd) mem_rdata <= dev_mem[mem_addr];
        else mem_rdata <= WIDTH'($urandom);
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one operation at a time, timed from its grant and handshake cycles.
    bit               m_active = 1'b0, m_ptr = 1'b0, m_owner, m_wr;
    logic [AW-1:0]    m_addr;
    logic [WIDTH-1:0] m_wdata, m_rdexp;
    int               m_hs, m_rsp;
    logic [WIDTH-1:0] refmem [DEPTH];
    logic [WIDTH-1:0] exp_rdata [2];

    // Observations recorded from the DUT for the directed literal checks.
    bit               o_gnt [2];
    int               o_gnt_cyc [2];
    int               o_rsp_cyc [2];
    logic [WIDTH-1:0] o_rsp_data [2];
    int               o_hs_cyc = 0, o_rsp_cnt = 0;
    logic [AW-1:0]    o_hs_addr;
    logic [WIDTH-1:0] o_hs_data;
    int               o_log [$];

    logic [1:0] v, e_rdy, e_rsp;
    logic       e_mv;
    bit         g;

    always @(negedge clk) begin
        cyc++;
        e_rdy = '0;
        e_rsp = '0;
        e_mv  = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_ptr = 1'b0;
            exp_rdata[0] = '0;
            exp_rdata[1] = '0;
            chk("rst_mem_wr_rd", 64'(mem_wr_rd), 64'(0));
            chk("rst_mem_addr", 64'(mem_addr), 64'(0));
            chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        end else if (!m_active) begin
            v = {req_valid_1, req_valid_0};
            if (v != 2'b00) begin
                g = (v == 2'b11) ? m_ptr : v[1];
                e_rdy[g] = 1'b1;
                m_active = 1'b1;
                m_owner = g;
                m_wr    = g ? req_wr_rd_1 : req_wr_rd_0;
                m_addr  = g ? req_addr_1 : req_addr_0;
                m_wdata = g ? req_wdata_1 : req_wdata_0;
                m_hs    = -1;
                m_ptr   = ~g;
            end
        end else if (m_hs < 0) begin
            e_mv = 1'b1;
            chk("mem_wr_rd", 64'(mem_wr_rd), 64'(m_wr));
            chk("mem_addr", 64'(mem_addr), 64'(m_addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            if (mem_ready) begin
                m_hs  = cyc;
                m_rsp = cyc + (m_wr ? 1 : 2);
                if (m_wr) refmem[m_addr] = m_wdata;
                else m_rdexp = refmem[m_addr];
            end
        end else if (cyc == m_rsp) begin
            e_rsp[m_owner] = 1'b1;
            if (!m_wr) exp_rdata[m_owner] = m_rdexp;
            m_active = 1'b0;
        end
        chk("req_ready", 64'({req_ready_1, req_ready_0}), 64'(e_rdy));
        chk("mem_valid", 64'(mem_valid), 64'(e_mv));
        chk("rsp_valid", 64'({rsp_valid_1, rsp_valid_0}), 64'(e_rsp));
        chk("rsp_rdata_0", 64'(rsp_rdata_0), 64'(exp_rdata[0]));
        chk("rsp_rdata_1", 64'(rsp_rdata_1), 64'(exp_rdata[1]));

        o_gnt[0] = req_ready_0;
        o_gnt[1] = req_ready_1;
        if (req_ready_0) begin o_gnt_cyc[0] = cyc; o_log.push_back(0); end
        if (req_ready_1) begin o_gnt_cyc[1] = cyc; o_log.push_back(1); end
        if (rsp_valid_0) begin o_rsp_cyc[0] = cyc; o_rsp_data[0] = rsp_rdata_0; o_rsp_cnt++; end
        if (rsp_valid_1) begin o_rsp_cyc[1] = cyc; o_rsp_data[1] = rsp_rdata_1; o_rsp_cnt++; end
        if (mem_valid && mem_ready) begin
            o_hs_cyc = cyc;
            o_hs_addr = mem_addr;
            o_hs_data = mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input bit vld, input bit wr,
                           input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        if (n == 0) begin
            req_valid_0 = vld; req_wr_rd_0 = wr; req_addr_0 = a; req_wdata_0 = d;
        end else begin
            req_valid_1 = vld; req_wr_rd_1 = wr; req_addr_1 = a; req_wdata_1 = d;
        end
    endtask

    task automatic set_rand(input int n, input bit vld);
        set_req(n, vld, 1'($urandom), AW'($urandom), WIDTH'($urandom));
    endtask

    // Present a request and hold it until granted; returns in the cycle after the grant.
    task automatic issue(input int n, input bit wr, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        int k = 0;
        set_req(n, 1'b1, wr, a, d);
        do begin tick(); k++; end while (!o_gnt[n] && k < 100);
        chk("grant_wait", 64'(o_gnt[n]), 64'(1));
        set_req(n, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (m_active && k < 100) begin tick(); k++; end
        chk("idle_wait", 64'(k < 100), 64'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [WIDTH-1:0] sweep [DEPTH];
    int cnt;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            dev_mem[i] = '0;
            refmem[i] = '0;
        end
        tick();
        tick();
        rst = 1'b0;

        // Single write, then single read of the same location.
        issue(0, 1'b1, 4'd3, 16'hA5A5);
        wait_idle();
        chk("t1_rsp_latency", 64'(o_rsp_cyc[0] - o_gnt_cyc[0]), 64'(2));
        chk("t1_hs_latency", 64'(o_hs_cyc - o_gnt_cyc[0]), 64'(1));
        chk("t1_hs_addr", 64'(o_hs_addr), 64'(3));
        chk("t1_hs_data", 64'(o_hs_data), 64'(16'hA5A5));
        issue(1, 1'b0, 4'd3, '0);
        wait_idle();
        chk("t2_rsp_latency", 64'(o_rsp_cyc[1] - o_gnt_cyc[1]), 64'(3));
        chk("t2_rdata", 64'(o_rsp_data[1]), 64'(16'hA5A5));

        // Contention from reset: grants alternate starting with requester 0.
        do_reset();
        o_log.delete();
        set_rand(0, 1'b1);
        set_rand(1, 1'b1);
        repeat (20) begin
            tick();
            for (int n = 0; n < 2; n++) if (o_gnt[n]) set_rand(n, 1'b1);
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        chk("t3_grant_count", 64'(o_log.size() >= 4), 64'(1));
        for (int i = 0; i < 4; i++)
            chk("t3_grant_order", 64'(o_log.size() > i ? o_log[i] : -1), 64'(i % 2));
        wait_idle();

        // Five stalled ISSUE cycles delay the response by five.
        mem_ready = 1'b0;
        set_req(0, 1'b1, 1'b1, 4'd5, 16'h1234);
        tick();
        chk("t4_grant", 64'(o_gnt[0]), 64'(1));
        set_req(0, 1'b0, 1'b0, '0, '0);
        repeat (5) tick();
        mem_ready = 1'b1;
        wait_idle();
        chk("t4_hs_latency", 64'(o_hs_cyc - o_gnt_cyc[0]), 64'(6));
        chk("t4_rsp_latency", 64'(o_rsp_cyc[0] - o_gnt_cyc[0]), 64'(7));

        // Reset while waiting for read data aborts the read.
        issue(1, 1'b0, 4'd7, '0);
        tick();
        cnt = o_rsp_cnt;
        rst = 1'b1;
        set_req(0, 1'b1, 1'b0, 4'd1, '0);
        set_req(1, 1'b1, 1'b0, 4'd2, '0);
        tick();
        tick();
        rst = 1'b0;
        o_log.delete();
        tick();
        chk("t5_first_grant", 64'(o_log.size() > 0 ? o_log[0] : -1), 64'(0));
        chk("t5_no_abort_rsp", 64'(o_rsp_cnt - cnt), 64'(0));
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        wait_idle();

        // Full sweep: requester 0 writes every address, requester 1 reads them back.
        for (int a = 0; a < DEPTH; a++) begin
            sweep[a] = WIDTH'($urandom);
            issue(0, 1'b1, AW'(a), sweep[a]);
            wait_idle();
        end
        for (int a = 0; a < DEPTH; a++) begin
            issue(1, 1'b0, AW'(a), '0);
            wait_idle();
            chk("t6_sweep_rdata", 64'(o_rsp_data[1]), 64'(sweep[a]));
        end

        // Randomized traffic with memory stalls and occasional resets.
        repeat (3000) begin
            for (int n = 0; n < 2; n++)
                if (!(n == 0 ? req_valid_0 : req_valid_1) || o_gnt[n])
                    set_rand(n, $urandom_range(99) < 60);
            mem_ready = ($urandom_range(3) != 0);
            rst = ($urandom_range(299) == 0);
            tick();
        end
        rst = 1'b0;
        mem_ready = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DEPTH, default 16, number of memory locations.
REQ-002 Parameter WIDTH, default 16, data width in bits.
REQ-003 Parameter ADDR_WIDTH, default $clog2(DEPTH), address width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req_valid_0, req_valid_1  input  1 each  requester N has a pending access.
REQ-007 req_wr_rd_0, req_wr_rd_1  input  1 each  1 = write, 0 = read.
REQ-008 req_addr_0, req_addr_1  input  ADDR_WIDTH each  access address.
REQ-009 req_wdata_0, req_wdata_1  input  WIDTH each  write data.
REQ-010 req_ready_0, req_ready_1  output  1 each  one-cycle grant pulse; the request is accepted on this cycle.
REQ-011 rsp_valid_0, rsp_valid_1  output  1 each  one-cycle completion pulse for a write or a read.
REQ-012 rsp_rdata_0, rsp_rdata_1  output  WIDTH each  read data, meaningful only while rsp_valid_N=1 for a read.
REQ-013 mem_valid  output  1  memory request valid.
REQ-014 mem_wr_rd  output  1  memory direction.
REQ-015 mem_addr  output  ADDR_WIDTH  memory address.
REQ-016 mem_wdata  output  WIDTH  memory write data.
REQ-017 mem_rdata  input  WIDTH  memory read data, valid the cycle after a read handshake.
REQ-018 mem_ready  input  1  memory accepts the request when mem_valid=1 and mem_ready=1 at posedge.

Function
REQ-019 The FSM SHALL have four states: IDLE, ISSUE, RDWAIT and RESP.
REQ-020 IDLE: with any req_valid_N=1, the arbiter SHALL grant one requester, pulse req_ready_N for that cycle, latch its wr_rd/addr/wdata, and go to ISSUE.
REQ-021 Arbitration SHALL be round-robin: a priority pointer selects which requester wins when both are valid; after a grant the pointer SHALL point to the non-granted requester.
REQ-022 With only one req_valid_N=1, that requester SHALL be granted regardless of the pointer, and the pointer SHALL still update per REQ-021.
REQ-023 ISSUE: mem_valid=1 with the latched fields held stable until the handshake; the state SHALL be held indefinitely while mem_ready=0.
REQ-024 ISSUE handshake, write: next state SHALL be RESP.
REQ-025 ISSUE handshake, read: next state SHALL be RDWAIT.
REQ-026 RDWAIT: mem_valid=0; mem_rdata SHALL be captured into rsp_rdata of the owner; next state SHALL be RESP.
REQ-027 RESP: rsp_valid of the owner SHALL be 1 for exactly one cycle; next state SHALL be IDLE.
REQ-028 Latency with mem_ready=1 from the grant cycle: write rsp at +2 cycles; read rsp at +3 cycles.
REQ-029 Outside ISSUE, mem_valid SHALL be 0; outside RESP, all rsp_valid_N SHALL be 0; outside IDLE, all req_ready_N SHALL be 0.
REQ-030 At most one req_ready_N and at most one rsp_valid_N SHALL be 1 in any cycle.
REQ-031 A requester SHALL hold req_valid_N and its fields stable until req_ready_N; the arbiter does not sample them at any other time.
REQ-032 rsp_rdata_N SHALL hold its last captured value until the next read for N completes.
REQ-033 Back-to-back operation: a new grant SHALL be possible in the IDLE cycle immediately following RESP.

Reset
REQ-034 rst=1 SHALL immediately force: state IDLE, pointer to requester 0, and all outputs (req_ready_N, rsp_valid_N, rsp_rdata_N, mem_valid, mem_wr_rd, mem_addr, mem_wdata) to 0.
REQ-035 Reset during ISSUE, RDWAIT or RESP SHALL abort the operation; no rsp_valid SHALL be produced for the aborted operation.
REQ-036 After rst deasserts, the first grant SHALL occur on the first posedge with a req_valid_N=1.

Verification
REQ-037 Single write: req_valid_0=1, write, addr=3, wdata=16'hA5A5, mem_ready=1 -> req_ready_0 at cycle 0, mem handshake at cycle 1 with addr 3 and data A5A5, rsp_valid_0 at cycle 2.
REQ-038 Single read: req_valid_1=1, read, addr=3, memory returns 16'hA5A5 -> rsp_valid_1 at +3 cycles with rsp_rdata_1=16'hA5A5.
REQ-039 Contention: both requesters valid continuously after reset -> grants alternate 0,1,0,1 over four operations, with no two grants overlapping.
REQ-040 Stall: mem_ready=0 for 5 cycles in ISSUE -> mem_valid/addr/wdata stay stable for all 5 cycles, and rsp_valid is delayed by exactly 5 cycles.
REQ-041 Reset mid-read: rst asserted in RDWAIT -> all outputs become 0 immediately, with no rsp_valid; the next request after reset is granted to requester 0 if both are valid.
REQ-042 Full sweep: requester 0 writes addresses 0..DEPTH-1, then requester 1 reads addresses 0..DEPTH-1 -> every rsp_rdata_1 equals the data written to that address.
